// File: rtl/cu_microsequencer_pkg.sv
// rtl/cu_microsequencer_pkg.sv - control-word field map, advance codes and reset word
package cu_microsequencer_pkg;

    localparam int CU_UPC_W = 10;
    localparam int CU_CW_W  = 62;

    localparam logic [CU_UPC_W-1:0] CU_RESET_UPC = 10'h000;
    localparam logic [CU_UPC_W-1:0] CU_IRQ_UPC   = 10'h3F0;

    localparam int CU_ADV_LSB    = 30;
    localparam int CU_ADV_W      = 2;
    localparam int DB_NREAD_BIT  = 32;
    localparam int DB_NWRITE_BIT = 4;
    localparam int CU_TAG_LSB    = 52;
    localparam int CU_TAG_W      = 10;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    typedef enum logic [1:0] {
        ADV_SEQ      = 2'b00,
        ADV_DISPATCH = 2'b01,
        ADV_COND     = 2'b10,
        ADV_HOLD     = 2'b11
    } adv_e;

    typedef enum logic [1:0] {
        PH_NORMAL  = 2'b00,
        PH_CB_PEND = 2'b01,
        PH_CB_EXEC = 2'b10
    } prefix_state_e;

    // Bus strobes idle high; DISPATCH so a stray micro-PC recovers at the next opcode.
    localparam logic [CU_CW_W-1:0] RESET_WORD =
        (62'd1 << DB_NREAD_BIT) | (62'd1 << DB_NWRITE_BIT) |
        (62'(ADV_DISPATCH) << CU_ADV_LSB);

    function automatic logic [CU_CW_W-1:0] mk_word(adv_e adv, logic [CU_TAG_W-1:0] tag);
        logic [CU_CW_W-1:0] w;
        w = RESET_WORD;
        w[CU_ADV_LSB +: CU_ADV_W] = adv;
        w[CU_TAG_LSB +: CU_TAG_W] = tag;
        return w;
    endfunction

endpackage

// File: rtl/cu_microsequencer_if.sv
// rtl/cu_microsequencer_if.sv - sequencer <-> datapath/bus signal bundle
interface cu_microsequencer_if
    import cu_microsequencer_pkg::*;
#(
    parameter int UPC_W = CU_UPC_W,
    parameter int CW_W  = CU_CW_W
);
    logic [7:0]       inst_byte;
    logic             mem_ready;
    logic             cond_true;
    logic             irq_req;
    logic [CW_W-1:0]  control_signals;
    logic [UPC_W-1:0] upc;
    logic             inst_start;
    logic             irq_ack;
    logic             cb_active;

    modport master (
        input  inst_byte, mem_ready, cond_true, irq_req,
        output control_signals, upc, inst_start, irq_ack, cb_active
    );

    modport slave (
        output inst_byte, mem_ready, cond_true, irq_req,
        input  control_signals, upc, inst_start, irq_ack, cb_active
    );
endinterface

// File: rtl/cu_microsequencer_rom.sv
// rtl/cu_microsequencer_rom.sv - combinational microcode store and opcode dispatch table
module microcode_rom
    import cu_microsequencer_pkg::*;
(
    input  logic [CU_UPC_W-1:0] addr,
    output logic [CU_CW_W-1:0]  word,
    input  logic [8:0]          dtab_idx,
    output logic [CU_UPC_W-1:0] dtab_addr
);
    adv_e adv;
    logic prog;

    // Programmed words carry their own address in the tag field for trace/debug.
    always_comb begin
        adv  = ADV_SEQ;
        prog = 1'b1;
        case (addr)
            10'h000, 10'h010, 10'h031, 10'h068:
                adv = ADV_HOLD;
            10'h001, 10'h011, 10'h023, 10'h032, 10'h043, 10'h050, 10'h061, 10'h06A:
                adv = ADV_DISPATCH;
            10'h041, 10'h069:
                adv = ADV_COND;
            10'h020, 10'h021, 10'h022, 10'h030, 10'h040, 10'h042, 10'h060:
                adv = ADV_SEQ;
            default:
                prog = (addr >= CU_IRQ_UPC);
        endcase
        word = prog ? mk_word(adv, addr) : RESET_WORD;
    end

    // Upper half of the table (index bit 8) holds the CB-prefixed routines.
    always_comb begin
        dtab_addr = 10'h020;
        if (dtab_idx[8]) begin
            dtab_addr = dtab_idx[0] ? 10'h068 : 10'h060;
        end else if (dtab_idx[7:0] == CB_PREFIX) begin
            dtab_addr = 10'h010;
        end else begin
            case (dtab_idx[1:0])
                2'd0:    dtab_addr = 10'h020;
                2'd1:    dtab_addr = 10'h030;
                2'd2:    dtab_addr = 10'h040;
                default: dtab_addr = 10'h050;
            endcase
        end
    end
endmodule

// File: rtl/cu_microsequencer.sv
// rtl/cu_microsequencer.sv - micro-PC, next-address select, CB prefix and IRQ entry
module cu_microsequencer
    import cu_microsequencer_pkg::*;
#(
    parameter int               UPC_W     = CU_UPC_W,
    parameter int               CW_W      = CU_CW_W,
    parameter logic [UPC_W-1:0] RESET_UPC = CU_RESET_UPC,
    parameter logic [UPC_W-1:0] IRQ_UPC   = CU_IRQ_UPC
) (
    input  logic                clk,
    input  logic                rst,
    cu_microsequencer_if.master bus
);
    logic [UPC_W-1:0] upc_q;
    logic [UPC_W-1:0] upc_inc;
    logic [UPC_W-1:0] next_upc;
    logic [UPC_W-1:0] dtab_addr;
    logic [CW_W-1:0]  cs_q;
    logic [CW_W-1:0]  rom_word;
    prefix_state_e    state_q;
    prefix_state_e    state_d;
    adv_e             adv;
    logic             cb_pend;
    logic             do_dispatch;
    logic             take_irq;
    logic             inst_start_q;
    logic             irq_ack_q;

    assign cb_pend = (state_q == PH_CB_PEND);

    microcode_rom u_rom (
        .addr      (next_upc),
        .word      (rom_word),
        .dtab_idx  ({cb_pend, bus.inst_byte}),
        .dtab_addr (dtab_addr)
    );

    always_comb begin
        adv         = adv_e'(cs_q[CU_ADV_LSB +: CU_ADV_W]);
        upc_inc     = upc_q + UPC_W'(1);
        next_upc    = upc_inc;
        do_dispatch = 1'b0;
        case (adv)
            ADV_SEQ:      next_upc = upc_inc;
            ADV_DISPATCH: do_dispatch = 1'b1;
            ADV_COND:     do_dispatch = !bus.cond_true;
            default:      next_upc = bus.mem_ready ? upc_inc : upc_q;
        endcase
        // A pending prefix keeps the interrupt out until its operand is dispatched.
        take_irq = do_dispatch && !cb_pend && bus.irq_req;
        if (do_dispatch) begin
            next_upc = take_irq ? IRQ_UPC : dtab_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_dispatch) begin
            case (state_q)
                PH_CB_PEND: state_d = PH_CB_EXEC;
                default:    state_d = (!bus.irq_req && bus.inst_byte == CB_PREFIX)
                                      ? PH_CB_PEND : PH_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q        <= RESET_UPC;
            cs_q         <= RESET_WORD;
            inst_start_q <= 1'b0;
            irq_ack_q    <= 1'b0;
        end else begin
            upc_q        <= next_upc;
            cs_q         <= rom_word;
            inst_start_q <= do_dispatch && !take_irq;
            irq_ack_q    <= take_irq;
        end
    end

    assign bus.control_signals = cs_q;
    assign bus.upc             = upc_q;
    assign bus.inst_start      = inst_start_q;
    assign bus.irq_ack         = irq_ack_q;
    assign bus.cb_active       = (state_q == PH_CB_EXEC);
endmodule

// File: tb/tb_cu_microsequencer.sv
// tb/tb_cu_microsequencer.sv - directed and random check of cu_microsequencer against a routine-level model
module tb_cu_microsequencer;
    localparam logic [61:0] EXP_RESET_WORD = 62'h0000_0001_4000_0010;
    localparam logic [9:0]  EXP_IRQ_UPC    = 10'h3F0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cu_microsequencer_if bus ();

    cu_microsequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Microprogram as a list of routines: S=seq D=dispatch C=cond H=hold.
    logic [1:0] m_adv  [1024];
    bit         m_prog [1024];

    logic [9:0]  m_upc;
    logic [61:0] m_cs;
    bit          m_pend, m_active, m_start, m_ack;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic prog_routine(input logic [9:0] base, input string codes);
        for (int i = 0; i < codes.len(); i++) begin
            m_prog[base + 10'(i)] = 1'b1;
            case (codes[i])
                "S":     m_adv[base + 10'(i)] = 2'd0;
                "D":     m_adv[base + 10'(i)] = 2'd1;
                "C":     m_adv[base + 10'(i)] = 2'd2;
                default: m_adv[base + 10'(i)] = 2'd3;
            endcase
        end
    endtask

    function automatic logic [61:0] word_at(input logic [9:0] a);
        logic [61:0] w;
        w = EXP_RESET_WORD;
        if (m_prog[a]) begin
            w[31:30] = m_adv[a];
            w[61:52] = a;
        end
        return w;
    endfunction

    function automatic logic [9:0] dtab(input bit cb, input logic [7:0] op);
        if (cb) return op[0] ? 10'h068 : 10'h060;
        if (op == 8'hCB) return 10'h010;
        return 10'h020 + 10'(op[1:0]) * 10'h010;
    endfunction

    task automatic model_step(input bit r, input logic [7:0] ib, input bit mr, input bit ct, input bit iq);
        logic [9:0] nxt;
        bit disp, irq;
        if (r) begin
            m_upc = 10'h000; m_cs = EXP_RESET_WORD;
            m_pend = 0; m_active = 0; m_start = 0; m_ack = 0;
            return;
        end
        disp = 0;
        nxt  = m_upc + 10'd1;
        case (m_cs[31:30])
            2'd1:    disp = 1;
            2'd2:    disp = !ct;
            2'd3:    if (!mr) nxt = m_upc;
            default: ;
        endcase
        irq     = disp && !m_pend && iq;
        m_start = disp && !irq;
        m_ack   = irq;
        if (disp) begin
            if (m_pend) begin
                nxt = dtab(1, ib); m_pend = 0; m_active = 1;
            end else if (iq) begin
                nxt = EXP_IRQ_UPC; m_active = 0;
            end else begin
                nxt = dtab(0, ib); m_active = 0; m_pend = (ib == 8'hCB);
            end
        end
        m_upc = nxt;
        m_cs  = word_at(nxt);
    endtask

    task automatic cycle(input bit r, input logic [7:0] ib, input bit mr, input bit ct, input bit iq);
        @(negedge clk);
        rst           = r;
        bus.inst_byte = ib;
        bus.mem_ready = mr;
        bus.cond_true = ct;
        bus.irq_req   = iq;
        model_step(r, ib, mr, ct, iq);
        @(posedge clk);
        #1;
        check_eq("upc",        64'(bus.upc),             64'(m_upc));
        check_eq("ctrl_word",  64'(bus.control_signals), 64'(m_cs));
        check_eq("inst_start", 64'(bus.inst_start),      64'(m_start));
        check_eq("irq_ack",    64'(bus.irq_ack),         64'(m_ack));
        check_eq("cb_active",  64'(bus.cb_active),       64'(m_active));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_prog[i] = 1'b0;
            m_adv[i]  = 2'd1;
        end
        prog_routine(10'h000, "HD");
        prog_routine(10'h010, "HD");
        prog_routine(10'h020, "SSSD");
        prog_routine(10'h030, "SHD");
        prog_routine(10'h040, "SCSD");
        prog_routine(10'h050, "D");
        prog_routine(10'h060, "SD");
        prog_routine(10'h068, "HCD");
        prog_routine(10'h3F0, "SSSSSSSSSSSSSSSS");

        bus.inst_byte = 8'h00; bus.mem_ready = 1'b0; bus.cond_true = 1'b0; bus.irq_req = 1'b0;

        // Reset release
        for (int i = 0; i < 3; i++) cycle(1, 8'h00, 0, 0, 0);
        check_eq("rst_upc", 64'(bus.upc), 64'h000);
        check_eq("rst_word", 64'(bus.control_signals), 64'(EXP_RESET_WORD));
        cycle(0, 8'h00, 0, 0, 0);
        check_eq("rel_upc", 64'(bus.upc), 64'h020);
        check_eq("rel_start", 64'(bus.inst_start), 64'd1);

        // SEQ routine then HOLD routine
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 0, 0);
        check_eq("seq_end", 64'(bus.upc), 64'h023);
        cycle(0, 8'h01, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 0, 0);
        check_eq("hold_stay", 64'(bus.upc), 64'h031);
        cycle(0, 8'h00, 1, 0, 0);
        check_eq("hold_rel", 64'(bus.upc), 64'h032);

        // COND taken and not taken
        cycle(0, 8'h02, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        check_eq("cond_true", 64'(bus.upc), 64'h042);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'h3E, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'h3E, 0, 0, 0);
        check_eq("cond_false", 64'(bus.upc), 64'h040);
        check_eq("cond_start", 64'(bus.inst_start), 64'd1);

        // CB prefix with interrupt pending across the prefix
        cycle(0, 8'h00, 0, 0, 0);
        cycle(0, 8'hCB, 0, 0, 0);
        check_eq("cb_prefix", 64'(bus.upc), 64'h010);
        cycle(0, 8'h00, 1, 0, 1);
        cycle(0, 8'h37, 0, 0, 1);
        check_eq("cb_target", 64'(bus.upc), 64'h068);
        check_eq("cb_active", 64'(bus.cb_active), 64'd1);
        check_eq("cb_no_ack", 64'(bus.irq_ack), 64'd0);
        cycle(0, 8'h00, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check_eq("irq_entry", 64'(bus.upc), 64'(EXP_IRQ_UPC));
        check_eq("irq_ack", 64'(bus.irq_ack), 64'd1);

        // IRQ routine runs off the top of the micro-address space
        for (int i = 0; i < 15; i++) cycle(0, 8'h00, 0, 0, 0);
        check_eq("upc_top", 64'(bus.upc), 64'h3FF);
        cycle(0, 8'h00, 0, 0, 0);
        check_eq("upc_wrap", 64'(bus.upc), 64'h000);

        // Reset while holding with a prefix pending
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'hCB, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        cycle(1, 8'h00, 0, 0, 0);
        check_eq("mid_rst_upc", 64'(bus.upc), 64'h000);
        check_eq("mid_rst_word", 64'(bus.control_signals), 64'(EXP_RESET_WORD));
        cycle(0, 8'h37, 0, 0, 0);
        check_eq("post_rst_plain", 64'(bus.upc), 64'h050);
        check_eq("post_rst_cb", 64'(bus.cb_active), 64'd0);

        // Random traffic in lockstep with the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ib;
            ib = ($urandom_range(0, 7) == 0) ? 8'hCB : 8'($urandom);
            cycle($urandom_range(0, 63) == 0, ib, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
